scurve_sweep_ctrl: RTL

Sequencer for the full S-curve scan. It steps the ASIC channel selection and the trigger-threshold DAC code over a programmed range. At each point it loads the DAC, waits for the threshold to settle, writes a two-word point header into the readout FIFO, fires the single-channel S-curve test, and waits for that test's `One_Channel_Done`. It sits between the slow-control/USB command decoder and the single-channel S-curve test block. It shares the downstream FIFO write port with that block's `SCurve_Data`/`SCurve_Data_wr_en`.

---
 rtl/scurve_sweep_ctrl_pkg.sv | 20 ++
 rtl/scurve_sweep_ctrl_if.sv | 34 +++
 rtl/scurve_sweep_ctrl_settle_timer.sv | 25 ++
 rtl/scurve_sweep_ctrl.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/scurve_sweep_ctrl_pkg.sv
// scurve_sweep_ctrl_pkg: state encoding, field widths and header constants for the S-curve sweep sequencer.
package scurve_sweep_ctrl_pkg;
  localparam int CHN_W = 6;
  localparam int DAC_W = 10;
  localparam logic [3:0] HDR_TAG = 4'hA;
  localparam logic [15:0] DEF_TRAILER = 16'hFFFF;
  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD_DAC,
    S_WAIT_DAC,
    S_SETTLE,
    S_HDR0,
    S_HDR1,
    S_FIRE,
    S_WAIT_TEST,
    S_NEXT,
    S_TRAILER,
    S_DONE
  } state_e;
endpackage

// File: rtl/scurve_sweep_ctrl_if.sv
// scurve_sweep_ctrl_if: command, DAC, test and FIFO-header signals of the sweep sequencer.
interface scurve_sweep_ctrl_if;
  import scurve_sweep_ctrl_pkg::*;
  logic             Sweep_Start;
  logic             Sweep_Abort;
  logic [CHN_W-1:0] Start_Chn;
  logic [CHN_W-1:0] End_Chn;
  logic [DAC_W-1:0] Start_DAC;
  logic [DAC_W-1:0] End_DAC;
  logic [DAC_W-1:0] DAC_Step;
  logic             DAC_Load_Done;
  logic             One_Channel_Done;
  logic             Fifo_Full;
  logic [CHN_W-1:0] Chn_Select;
  logic [DAC_W-1:0] DAC_Code;
  logic             DAC_Load;
  logic             SCurve_Test_Start;
  logic [15:0]      Header_Data;
  logic             Header_wr_en;
  logic             Sweep_Busy;
  logic             Sweep_Done;
  modport master (
    input  Sweep_Start, Sweep_Abort, Start_Chn, End_Chn, Start_DAC, End_DAC, DAC_Step,
           DAC_Load_Done, One_Channel_Done, Fifo_Full,
    output Chn_Select, DAC_Code, DAC_Load, SCurve_Test_Start, Header_Data, Header_wr_en,
           Sweep_Busy, Sweep_Done
  );
  modport slave (
    output Sweep_Start, Sweep_Abort, Start_Chn, End_Chn, Start_DAC, End_DAC, DAC_Step,
           DAC_Load_Done, One_Channel_Done, Fifo_Full,
    input  Chn_Select, DAC_Code, DAC_Load, SCurve_Test_Start, Header_Data, Header_wr_en,
           Sweep_Busy, Sweep_Done
  );
endinterface

// File: rtl/scurve_sweep_ctrl_settle_timer.sv
// settle_timer: after a start pulse, pulses done_o on the tc_i-th following cycle.
module settle_timer (
  input  logic        Clk,
  input  logic        reset_n,
  input  logic        start_i,
  input  logic [15:0] tc_i,
  output logic        done_o
);
  logic [15:0] cnt_q, cnt_d;
  logic        run_q, run_d;
  assign done_o = run_q && (cnt_q == tc_i - 16'd1);
  always_comb begin
    cnt_d = start_i ? 16'd0 : run_q ? cnt_q + 16'd1 : cnt_q;
    run_d = start_i ? 1'b1 : done_o ? 1'b0 : run_q;
  end
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end
endmodule

// File: rtl/scurve_sweep_ctrl.sv
// scurve_sweep_ctrl: steps channel (outer) and DAC code (inner) over latched ranges,
// writing a two-word header per point and firing the single-channel S-curve test.
module scurve_sweep_ctrl
  import scurve_sweep_ctrl_pkg::*;
#(
  parameter int          SETTLE_CYCLES = 400,
  parameter logic [15:0] TRAILER_WORD  = DEF_TRAILER
) (
  input logic                 Clk,
  input logic                 reset_n,
  scurve_sweep_ctrl_if.master bus
);
  localparam logic [15:0] SETTLE_TC = 16'(SETTLE_CYCLES);
  state_e           state_q, state_d;
  logic [CHN_W-1:0] chn_q, chn_d, end_chn_q, end_chn_d;
  logic [DAC_W-1:0] dac_q, dac_d, start_dac_q, start_dac_d, end_dac_q, end_dac_d, step_q, step_d;
  logic [15:0]      hdr_data_q, hdr_data_d;
  logic             dac_load_q, dac_load_d, test_start_q, test_start_d;
  logic             hdr_wr_q, hdr_wr_d, busy_q, busy_d, done_q, done_d;
  logic             start_prev_q;
  logic             settle_done, tmr_start;
  logic [DAC_W:0]   sum;
  assign sum       = {1'b0, dac_q} + {1'b0, step_q};
  assign tmr_start = (state_q == S_WAIT_DAC) && bus.DAC_Load_Done;
  settle_timer u_settle (
    .Clk     (Clk),
    .reset_n (reset_n),
    .start_i (tmr_start),
    .tc_i    (SETTLE_TC),
    .done_o  (settle_done)
  );
  always_comb begin
    state_d      = state_q;
    chn_d        = chn_q;
    dac_d        = dac_q;
    start_dac_d  = start_dac_q;
    end_chn_d    = end_chn_q;
    end_dac_d    = end_dac_q;
    step_d       = step_q;
    hdr_data_d   = hdr_data_q;
    dac_load_d   = 1'b0;
    test_start_d = 1'b0;
    hdr_wr_d     = 1'b0;
    done_d       = 1'b0;
    case (state_q)
      S_IDLE: if (bus.Sweep_Start && !start_prev_q) begin
        state_d     = S_LOAD_DAC;
        chn_d       = bus.Start_Chn;
        dac_d       = bus.Start_DAC;
        start_dac_d = bus.Start_DAC;
        // Inverted ranges collapse to the start value alone
        end_chn_d   = (bus.Start_Chn > bus.End_Chn) ? bus.Start_Chn : bus.End_Chn;
        end_dac_d   = (bus.Start_DAC > bus.End_DAC) ? bus.Start_DAC : bus.End_DAC;
        step_d      = (bus.DAC_Step == '0) ? DAC_W'(1) : bus.DAC_Step;
      end
      S_LOAD_DAC: begin
        dac_load_d = 1'b1;
        state_d    = S_WAIT_DAC;
      end
      S_WAIT_DAC: state_d = bus.DAC_Load_Done ? S_SETTLE : S_WAIT_DAC;
      S_SETTLE:   state_d = settle_done ? S_HDR0 : S_SETTLE;
      S_HDR0: if (!bus.Fifo_Full) begin
        hdr_wr_d   = 1'b1;
        hdr_data_d = {HDR_TAG, {(16-4-CHN_W){1'b0}}, chn_q};
        state_d    = S_HDR1;
      end
      S_HDR1: if (!bus.Fifo_Full) begin
        hdr_wr_d   = 1'b1;
        hdr_data_d = {{(16-DAC_W){1'b0}}, dac_q};
        state_d    = S_FIRE;
      end
      S_FIRE: begin
        test_start_d = 1'b1;
        state_d      = S_WAIT_TEST;
      end
      S_WAIT_TEST: state_d = bus.One_Channel_Done ? S_NEXT : S_WAIT_TEST;
      S_NEXT: begin
        // 11-bit sum: overflow past 1023 ends the channel instead of wrapping
        if (sum <= {1'b0, end_dac_q}) begin
          dac_d   = sum[DAC_W-1:0];
          state_d = S_LOAD_DAC;
        end else if (chn_q < end_chn_q) begin
          chn_d   = chn_q + CHN_W'(1);
          dac_d   = start_dac_q;
          state_d = S_LOAD_DAC;
        end else begin
          state_d = S_TRAILER;
        end
      end
      S_TRAILER: if (!bus.Fifo_Full) begin
        hdr_wr_d   = 1'b1;
        hdr_data_d = TRAILER_WORD;
        state_d    = S_DONE;
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (bus.Sweep_Abort && state_q != S_IDLE) begin
      state_d      = S_IDLE;
      chn_d        = chn_q;
      dac_d        = dac_q;
      hdr_data_d   = hdr_data_q;
      dac_load_d   = 1'b0;
      test_start_d = 1'b0;
      hdr_wr_d     = 1'b0;
      done_d       = 1'b0;
    end
    busy_d = (state_d != S_IDLE);
  end
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      chn_q        <= '0;
      dac_q        <= '0;
      start_dac_q  <= '0;
      end_chn_q    <= '0;
      end_dac_q    <= '0;
      step_q       <= '0;
      hdr_data_q   <= '0;
      dac_load_q   <= 1'b0;
      test_start_q <= 1'b0;
      hdr_wr_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      start_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      chn_q        <= chn_d;
      dac_q        <= dac_d;
      start_dac_q  <= start_dac_d;
      end_chn_q    <= end_chn_d;
      end_dac_q    <= end_dac_d;
      step_q       <= step_d;
      hdr_data_q   <= hdr_data_d;
      dac_load_q   <= dac_load_d;
      test_start_q <= test_start_d;
      hdr_wr_q     <= hdr_wr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      start_prev_q <= bus.Sweep_Start;
    end
  end
  assign bus.Chn_Select        = chn_q;
  assign bus.DAC_Code          = dac_q;
  assign bus.DAC_Load          = dac_load_q;
  assign bus.SCurve_Test_Start = test_start_q;
  assign bus.Header_Data       = hdr_data_q;
  assign bus.Header_wr_en      = hdr_wr_q;
  assign bus.Sweep_Busy        = busy_q;
  assign bus.Sweep_Done        = done_q;
endmodule
